// File: rtl/data_mem_mmio.sv
// Data-side responder for the single-cycle core: word RAM plus LED/SW/CYCLE/timer MMIO window.
// Optional timer block (TLOAD/TCTRL/TSTAT/TCNT, timer_irq) is built only when DMEM_TIMER_EN is defined.
module data_mem_mmio #(
    parameter int WORD_WIDTH     = 16,
    parameter int DMEM_DEPTH     = 256,
    parameter int DMEM_ADDR_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run_en,
    input  logic [WORD_WIDTH-1:0] mem_addr,
    input  logic [WORD_WIDTH-1:0] mem_write_data,
    input  logic                  mem_write_en,
    input  logic                  mem_read_en,
    output logic [WORD_WIDTH-1:0] mem_read_data,
    input  logic [WORD_WIDTH-1:0] sw_in,
    output logic [WORD_WIDTH-1:0] led_out,
    output logic                  timer_irq
);

    localparam logic [WORD_WIDTH-1:0] ADDR_LED   = 16'hFFF0;
    localparam logic [WORD_WIDTH-1:0] ADDR_SW    = 16'hFFF1;
    localparam logic [WORD_WIDTH-1:0] ADDR_CYCLE = 16'hFFF2;
`ifdef DMEM_TIMER_EN
    localparam logic [WORD_WIDTH-1:0] ADDR_TLOAD = 16'hFFF3;
    localparam logic [WORD_WIDTH-1:0] ADDR_TCTRL = 16'hFFF4;
    localparam logic [WORD_WIDTH-1:0] ADDR_TSTAT = 16'hFFF5;
    localparam logic [WORD_WIDTH-1:0] ADDR_TCNT  = 16'hFFF6;
`endif

    logic                      we_s;
    logic                      ram_hit_s;
    logic [DMEM_ADDR_BITS-1:0] ram_idx_s;
    logic [WORD_WIDTH-1:0]     mem_q [DMEM_DEPTH];
    logic [WORD_WIDTH-1:0]     led_q, led_d;
    logic [WORD_WIDTH-1:0]     cycle_q, cycle_d;
    logic [WORD_WIDTH-1:0]     sw_sync1_q, sw_sync1_d;
    logic [WORD_WIDTH-1:0]     sw_sync2_q, sw_sync2_d;
    logic [WORD_WIDTH-1:0]     rdata_s;

    assign we_s      = mem_write_en & run_en;
    assign ram_hit_s = (mem_addr[WORD_WIDTH-1:DMEM_ADDR_BITS] == '0);
    assign ram_idx_s = mem_addr[DMEM_ADDR_BITS-1:0];

    // Next-state for LED, cycle counter and switch synchronizer (sync runs even when paused)
    always_comb begin
        led_d      = led_q;
        cycle_d    = cycle_q;
        sw_sync1_d = sw_in;
        sw_sync2_d = sw_sync1_q;
        if (we_s && (mem_addr == ADDR_LED)) begin
            led_d = mem_write_data;
        end else begin
            led_d = led_q;
        end
        if (we_s && (mem_addr == ADDR_CYCLE)) begin
            cycle_d = '0;
        end else if (run_en) begin
            cycle_d = cycle_q + 16'd1;
        end else begin
            cycle_d = cycle_q;
        end
    end

    // Basic MMIO register state
    always_ff @(posedge clk) begin
        if (rst) begin
            led_q      <= '0;
            cycle_q    <= '0;
            sw_sync1_q <= '0;
            sw_sync2_q <= '0;
        end else begin
            led_q      <= led_d;
            cycle_q    <= cycle_d;
            sw_sync1_q <= sw_sync1_d;
            sw_sync2_q <= sw_sync2_d;
        end
    end

    // RAM store port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (we_s && ram_hit_s) begin
            mem_q[ram_idx_s] <= mem_write_data;
        end
    end

`ifdef DMEM_TIMER_EN
    typedef enum logic [0:0] {T_IDLE = 1'b0, T_COUNT = 1'b1} tstate_e;

    tstate_e               state_q, state_d;
    logic [WORD_WIDTH-1:0] tload_q, tload_d;
    logic [WORD_WIDTH-1:0] tcnt_q, tcnt_d;
    logic                  auto_q, auto_d;
    logic                  exp_q, exp_d;
    logic                  exp_set_s;
    logic                  tctrl_wr_s;
    logic                  timer_en_s;

    assign tctrl_wr_s = we_s && (mem_addr == ADDR_TCTRL);

    // Timer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= T_IDLE;
            tload_q <= '0;
            tcnt_q  <= '0;
            auto_q  <= 1'b0;
            exp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tload_q <= tload_d;
            tcnt_q  <= tcnt_d;
            auto_q  <= auto_d;
            exp_q   <= exp_d;
        end
    end

    // Timer next-state: a TCTRL write always overrides the decrement/expiry step
    always_comb begin
        state_d   = state_q;
        tload_d   = tload_q;
        tcnt_d    = tcnt_q;
        auto_d    = auto_q;
        exp_set_s = 1'b0;
        if (we_s && (mem_addr == ADDR_TLOAD)) begin
            tload_d = mem_write_data;
        end else begin
            tload_d = tload_q;
        end
        if (tctrl_wr_s) begin
            auto_d = mem_write_data[1];
        end else begin
            auto_d = auto_q;
        end
        case (state_q)
            T_IDLE: begin
                if (tctrl_wr_s && mem_write_data[0]) begin
                    tcnt_d  = tload_q;
                    state_d = T_COUNT;
                end else begin
                    state_d = T_IDLE;
                end
            end
            T_COUNT: begin
                if (tctrl_wr_s) begin
                    if (mem_write_data[0]) begin
                        tcnt_d = tload_q;
                    end else begin
                        state_d = T_IDLE;
                    end
                end else if (run_en) begin
                    if (tcnt_q != '0) begin
                        tcnt_d = tcnt_q - 16'd1;
                    end else if (auto_q) begin
                        exp_set_s = 1'b1;
                        tcnt_d    = tload_q;
                    end else begin
                        exp_set_s = 1'b1;
                        state_d   = T_IDLE;
                    end
                end else begin
                    state_d = T_COUNT;
                end
            end
            default: begin
                state_d = T_IDLE;
            end
        endcase
        // Expiry beats a simultaneous W1C
        if (exp_set_s) begin
            exp_d = 1'b1;
        end else if (we_s && (mem_addr == ADDR_TSTAT) && mem_write_data[0]) begin
            exp_d = 1'b0;
        end else begin
            exp_d = exp_q;
        end
    end

    // Timer outputs
    always_comb begin
        timer_en_s = (state_q == T_COUNT);
        timer_irq  = exp_q;
    end
`else
    assign timer_irq = 1'b0;
`endif

    // Combinational read mux; reads have no side effects
    always_comb begin
        rdata_s = '0;
        if (!mem_read_en) begin
            rdata_s = '0;
        end else if (ram_hit_s) begin
            rdata_s = mem_q[ram_idx_s];
        end else begin
            case (mem_addr)
                ADDR_LED:   rdata_s = led_q;
                ADDR_SW:    rdata_s = sw_sync2_q;
                ADDR_CYCLE: rdata_s = cycle_q;
`ifdef DMEM_TIMER_EN
                ADDR_TLOAD: rdata_s = tload_q;
                ADDR_TCTRL: rdata_s = {14'd0, auto_q, timer_en_s};
                ADDR_TSTAT: rdata_s = {15'd0, exp_q};
                ADDR_TCNT:  rdata_s = tcnt_q;
`endif
                default:    rdata_s = '0;
            endcase
        end
    end

    assign mem_read_data = rdata_s;
    assign led_out       = led_q;

endmodule

// File: tb/tb_data_mem_mmio.sv
// Directed self-checking bench for data_mem_mmio; timer checks follow DMEM_TIMER_EN.
module tb_data_mem_mmio;

    logic        clk;
    logic        rst;
    logic        run_en;
    logic [15:0] mem_addr;
    logic [15:0] mem_write_data;
    logic        mem_write_en;
    logic        mem_read_en;
    logic [15:0] mem_read_data;
    logic [15:0] sw_in;
    logic [15:0] led_out;
    logic        timer_irq;

    int total = 0;
    int bad   = 0;

    data_mem_mmio dut (
        .clk           (clk),
        .rst           (rst),
        .run_en        (run_en),
        .mem_addr      (mem_addr),
        .mem_write_data(mem_write_data),
        .mem_write_en  (mem_write_en),
        .mem_read_en   (mem_read_en),
        .mem_read_data (mem_read_data),
        .sw_in         (sw_in),
        .led_out       (led_out),
        .timer_irq     (timer_irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        mem_addr       = a;
        mem_write_data = d;
        mem_write_en   = 1'b1;
        tick();
        mem_write_en   = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] d);
        mem_addr    = a;
        mem_read_en = 1'b1;
        #1;
        d           = mem_read_data;
        mem_read_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] v;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++; if (led_out !== 16'h0000) begin bad++; $display("FAIL reset_led got=%h exp=0000", led_out); end
        total++; if (timer_irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", timer_irq); end
        rd(16'hFFF2, v);
        total++; if (v !== 16'h0000) begin bad++; $display("FAIL reset_cycle got=%h exp=0000", v); end
        rd(16'hFFF1, v);
        total++; if (v !== 16'h0000) begin bad++; $display("FAIL reset_sw got=%h exp=0000", v); end
    endtask

    task automatic test_ram();
        logic [15:0] v;
        wr(16'h0005, 16'h1234);
        rd(16'h0005, v);
        total++; if (v !== 16'h1234) begin bad++; $display("FAIL ram_rt got=%h exp=1234", v); end
        rd(16'h0100, v);
        total++; if (v !== 16'h0000) begin bad++; $display("FAIL ram_unmapped got=%h exp=0000", v); end
        mem_addr    = 16'h0005;
        mem_read_en = 1'b0;
        #1;
        total++; if (mem_read_data !== 16'h0000) begin bad++; $display("FAIL ram_no_re got=%h exp=0000", mem_read_data); end
        wr(16'h00FF, 16'hA5A5);
        rd(16'h00FF, v);
        total++; if (v !== 16'hA5A5) begin bad++; $display("FAIL ram_top got=%h exp=A5A5", v); end
        wr(16'h0000, 16'h1111);
        wr(16'h0100, 16'h2222);
        rd(16'h0000, v);
        total++; if (v !== 16'h1111) begin bad++; $display("FAIL ram_alias got=%h exp=1111", v); end
    endtask

    task automatic test_same_cycle_rw();
        logic [15:0] v;
        mem_addr       = 16'h0005;
        mem_write_data = 16'h5555;
        mem_write_en   = 1'b1;
        mem_read_en    = 1'b1;
        #1;
        v = mem_read_data;
        total++; if (v !== 16'h1234) begin bad++; $display("FAIL rw_old got=%h exp=1234", v); end
        tick();
        mem_write_en = 1'b0;
        mem_read_en  = 1'b0;
        rd(16'h0005, v);
        total++; if (v !== 16'h5555) begin bad++; $display("FAIL rw_new got=%h exp=5555", v); end
    endtask

    task automatic test_write_gating();
        logic [15:0] v;
        run_en         = 1'b0;
        mem_addr       = 16'hFFF0;
        mem_write_data = 16'hBEEF;
        mem_write_en   = 1'b1;
        tick();
        total++; if (led_out !== 16'h0000) begin bad++; $display("FAIL gate_led_held got=%h exp=0000", led_out); end
        run_en = 1'b1;
        tick();
        mem_write_en = 1'b0;
        total++; if (led_out !== 16'hBEEF) begin bad++; $display("FAIL gate_led_set got=%h exp=BEEF", led_out); end
        rd(16'hFFF0, v);
        total++; if (v !== 16'hBEEF) begin bad++; $display("FAIL gate_led_rd got=%h exp=BEEF", v); end
    endtask

    task automatic test_cycle();
        logic [15:0] v;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        rd(16'hFFF2, v);
        total++; if (v !== 16'd10) begin bad++; $display("FAIL cycle_run got=%h exp=000a", v); end
        run_en = 1'b0;
        repeat (5) tick();
        rd(16'hFFF2, v);
        total++; if (v !== 16'd10) begin bad++; $display("FAIL cycle_pause got=%h exp=000a", v); end
        run_en = 1'b1;
        wr(16'hFFF2, 16'h1234);
        rd(16'hFFF2, v);
        total++; if (v !== 16'h0000) begin bad++; $display("FAIL cycle_clear got=%h exp=0000", v); end
        tick();
        rd(16'hFFF2, v);
        total++; if (v !== 16'h0001) begin bad++; $display("FAIL cycle_after_clear got=%h exp=0001", v); end
        repeat (65534) @(posedge clk);
        #1;
        rd(16'hFFF2, v);
        total++; if (v !== 16'hFFFF) begin bad++; $display("FAIL cycle_max got=%h exp=FFFF", v); end
        tick();
        rd(16'hFFF2, v);
        total++; if (v !== 16'h0000) begin bad++; $display("FAIL cycle_wrap got=%h exp=0000", v); end
    endtask

    task automatic test_sw_sync();
        logic [15:0] v;
        sw_in = 16'h00A5;
        rd(16'hFFF1, v);
        total++; if (v !== 16'h0000) begin bad++; $display("FAIL sw_e0 got=%h exp=0000", v); end
        tick();
        rd(16'hFFF1, v);
        total++; if (v !== 16'h0000) begin bad++; $display("FAIL sw_e1 got=%h exp=0000", v); end
        tick();
        rd(16'hFFF1, v);
        total++; if (v !== 16'h00A5) begin bad++; $display("FAIL sw_e2 got=%h exp=00a5", v); end
    endtask

`ifdef DMEM_TIMER_EN
    task automatic test_timer_oneshot();
        logic [15:0] v;
        wr(16'hFFF3, 16'd3);
        wr(16'hFFF4, 16'h0001);
        rd(16'hFFF6, v);
        total++; if (v !== 16'd3) begin bad++; $display("FAIL tos_load got=%h exp=0003", v); end
        rd(16'hFFF4, v);
        total++; if (v !== 16'h0001) begin bad++; $display("FAIL tos_en got=%h exp=0001", v); end
        repeat (3) tick();
        total++; if (timer_irq !== 1'b0) begin bad++; $display("FAIL tos_early got=%b exp=0", timer_irq); end
        rd(16'hFFF6, v);
        total++; if (v !== 16'd0) begin bad++; $display("FAIL tos_zero got=%h exp=0000", v); end
        tick();
        total++; if (timer_irq !== 1'b1) begin bad++; $display("FAIL tos_irq got=%b exp=1", timer_irq); end
        rd(16'hFFF4, v);
        total++; if (v !== 16'h0000) begin bad++; $display("FAIL tos_idle got=%h exp=0000", v); end
        wr(16'hFFF5, 16'h0001);
        total++; if (timer_irq !== 1'b0) begin bad++; $display("FAIL tos_w1c got=%b exp=0", timer_irq); end
    endtask

    task automatic test_timer_stop();
        logic [15:0] v;
        wr(16'hFFF3, 16'd5);
        wr(16'hFFF4, 16'h0001);
        tick();
        wr(16'hFFF4, 16'h0000);
        rd(16'hFFF6, v);
        total++; if (v !== 16'd4) begin bad++; $display("FAIL tstop_hold got=%h exp=0004", v); end
        rd(16'hFFF4, v);
        total++; if (v !== 16'h0000) begin bad++; $display("FAIL tstop_idle got=%h exp=0000", v); end
    endtask

    task automatic test_timer_auto();
        logic [15:0] v;
        wr(16'hFFF3, 16'd1);
        wr(16'hFFF4, 16'h0003);
        tick();
        total++; if (timer_irq !== 1'b0) begin bad++; $display("FAIL tauto_e1 got=%b exp=0", timer_irq); end
        tick();
        total++; if (timer_irq !== 1'b1) begin bad++; $display("FAIL tauto_e2 got=%b exp=1", timer_irq); end
        wr(16'hFFF5, 16'h0001);
        total++; if (timer_irq !== 1'b0) begin bad++; $display("FAIL tauto_clr got=%b exp=0", timer_irq); end
        tick();
        total++; if (timer_irq !== 1'b1) begin bad++; $display("FAIL tauto_e4 got=%b exp=1", timer_irq); end
        rd(16'hFFF4, v);
        total++; if (v !== 16'h0003) begin bad++; $display("FAIL tauto_ctrl got=%h exp=0003", v); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rd(16'hFFF6, v);
        total++; if (v !== 16'h0000) begin bad++; $display("FAIL tauto_rst_cnt got=%h exp=0000", v); end
        total++; if (timer_irq !== 1'b0) begin bad++; $display("FAIL tauto_rst_irq got=%b exp=0", timer_irq); end
        rd(16'hFFF4, v);
        total++; if (v !== 16'h0000) begin bad++; $display("FAIL tauto_rst_idle got=%h exp=0000", v); end
    endtask
`else
    task automatic test_timer_absent();
        logic [15:0] v;
        for (int i = 3; i <= 6; i++) begin
            wr(16'hFFF0 + 16'(i), 16'h0003);
            rd(16'hFFF0 + 16'(i), v);
            total++; if (v !== 16'h0000) begin bad++; $display("FAIL tabs_rd%0d got=%h exp=0000", i, v); end
        end
        repeat (4) tick();
        total++; if (timer_irq !== 1'b0) begin bad++; $display("FAIL tabs_irq got=%b exp=0", timer_irq); end
    endtask
`endif

    task automatic test_reset_retention();
        logic [15:0] v;
        rst = 1'b1;
        mem_addr       = 16'hFFF0;
        mem_write_data = 16'h7777;
        mem_write_en   = 1'b1;
        tick();
        rst          = 1'b0;
        mem_write_en = 1'b0;
        total++; if (led_out !== 16'h0000) begin bad++; $display("FAIL rret_led got=%h exp=0000", led_out); end
        rd(16'h0005, v);
        total++; if (v !== 16'h5555) begin bad++; $display("FAIL rret_ram got=%h exp=5555", v); end
    endtask

    initial begin
        rst            = 1'b1;
        run_en         = 1'b1;
        mem_addr       = 16'h0000;
        mem_write_data = 16'h0000;
        mem_write_en   = 1'b0;
        mem_read_en    = 1'b0;
        sw_in          = 16'h0000;
        test_reset();
        test_ram();
        test_same_cycle_rw();
        test_write_gating();
        test_cycle();
        test_sw_sync();
`ifdef DMEM_TIMER_EN
        test_timer_oneshot();
        test_timer_stop();
        test_timer_auto();
`else
        test_timer_absent();
`endif
        test_reset_retention();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
